// File: rtl/bn_pipe_slice.sv
// bn_pipe_slice: elastic valid/ready pipeline slice between the BN FIFO read
// side and the batch-norm datapath. Carries CHANNELS signed data lanes, the
// per-beat BN parameter bundle and a last-of-tile marker over STAGES register
// stages. The FIFO empty/full flags ride a separate free-running sideband
// delayed by exactly STAGES cycles.
// Optional feature: define BN_PIPE_STALL_CNT_EN to add the saturating
// stall_cnt output (cycles with out_valid=1 and out_ready=0).
module bn_pipe_slice #(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 1,
  parameter int STAGES     = 2,
  parameter int CNT_W      = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
  input  logic [DATA_WIDTH-1:0]          in_mean,
  input  logic [DATA_WIDTH-1:0]          in_std,
  input  logic [DATA_WIDTH-1:0]          in_gamma,
  input  logic [DATA_WIDTH-1:0]          in_beta,
  input  logic                           in_last,
  input  logic                           fifo_empty_in,
  input  logic                           fifo_full_in,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [CHANNELS*DATA_WIDTH-1:0] out_data,
  output logic [DATA_WIDTH-1:0]          out_mean,
  output logic [DATA_WIDTH-1:0]          out_std,
  output logic [DATA_WIDTH-1:0]          out_gamma,
  output logic [DATA_WIDTH-1:0]          out_beta,
  output logic                           out_last,
  output logic                           fifo_empty_out,
  output logic                           fifo_full_out,
  output logic [$clog2(STAGES+1)-1:0]    occupancy
`ifdef BN_PIPE_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]               stall_cnt
`endif
);

  localparam int OCC_W = $clog2(STAGES + 1);

  // Reject configurations the slice cannot build.
  if (STAGES < 1 || CHANNELS < 1 || DATA_WIDTH < 1 || CNT_W < 1) begin : g_bad_cfg
    $error("bn_pipe_slice: STAGES, CHANNELS, DATA_WIDTH and CNT_W must all be >= 1");
  end

  // One beat: everything that moves together through the stages.
  typedef struct packed {
    logic [CHANNELS*DATA_WIDTH-1:0] data;
    logic [DATA_WIDTH-1:0]          mean;
    logic [DATA_WIDTH-1:0]          std;
    logic [DATA_WIDTH-1:0]          gamma;
    logic [DATA_WIDTH-1:0]          beta;
    logic                           last;
  } beat_t;

  beat_t             in_beat;
  beat_t             pay_q [STAGES];
  beat_t             pay_d [STAGES];
  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] empty_q, empty_d;
  logic [STAGES-1:0] full_q, full_d;
  logic [STAGES-1:0] ready;
  logic              in_take;

  assign in_beat = '{data: in_data, mean: in_mean, std: in_std,
                     gamma: in_gamma, beta: in_beta, last: in_last};
  assign in_take = in_valid && !flush;

  // Ready chain: stage i can load if it, or any stage downstream of it, is
  // empty, or the consumer accepts. Unrolled so the chain is a flat OR.
  always_comb begin : ready_chain
    logic hole;
    // NOTE: every variable written in always_comb gets a value before any
    // conditional logic, otherwise synthesis infers a latch.
    hole  = 1'b0;
    ready = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      hole     = hole | !valid_q[i];
      ready[i] = out_ready | hole;
    end
  end

  assign in_ready = ready[0] && !flush;

  // Next-state for stage valids and payloads; flush clears valids but leaves payloads alone.
  always_comb begin
    valid_d = valid_q;
    pay_d   = pay_q;
    if (ready[0]) begin
      valid_d[0] = in_take;
      if (in_take) pay_d[0] = in_beat;
    end
    for (int i = 1; i < STAGES; i++) begin
      if (ready[i]) begin
        valid_d[i] = valid_q[i-1];
        if (valid_q[i-1] && !flush) pay_d[i] = pay_q[i-1];
      end
    end
    if (flush) valid_d = '0;
  end

  // Sideband flags: plain shift register, advances every cycle.
  always_comb begin
    empty_d    = empty_q;
    full_d     = full_q;
    empty_d[0] = fifo_empty_in;
    full_d[0]  = fifo_full_in;
    for (int i = 1; i < STAGES; i++) begin
      empty_d[i] = empty_q[i-1];
      full_d[i]  = full_q[i-1];
    end
  end

  // Stage registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    if (rst) begin
      valid_q <= '0;
      empty_q <= '1;
      full_q  <= '0;
      // NOTE: the payload array is reset on purpose so out_* read as zero
      // after reset; it is small enough to live in flops, not RAM.
      for (int i = 0; i < STAGES; i++) pay_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      for (int i = 0; i < STAGES; i++) pay_q[i] <= pay_d[i];
    end
  end

  // Occupancy is the number of stages holding a valid beat.
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < STAGES; i++) occupancy = occupancy + OCC_W'(valid_q[i]);
  end

  assign out_valid      = valid_q[STAGES-1];
  assign out_data       = pay_q[STAGES-1].data;
  assign out_mean       = pay_q[STAGES-1].mean;
  assign out_std        = pay_q[STAGES-1].std;
  assign out_gamma      = pay_q[STAGES-1].gamma;
  assign out_beta       = pay_q[STAGES-1].beta;
  assign out_last       = pay_q[STAGES-1].last;
  assign fifo_empty_out = empty_q[STAGES-1];
  assign fifo_full_out  = full_q[STAGES-1];

`ifdef BN_PIPE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles where the output is held by backpressure.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (flush) begin
      stall_cnt_d = '0;
    end else if (out_valid && !out_ready && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_bn_pipe_slice.sv
// tb_bn_pipe_slice: self-checking bench for bn_pipe_slice (STAGES=2,
// CHANNELS=2). A scoreboard queue of beats in flight plus a queue-based
// sideband delay line act as the reference; directed sequences and a table
// of passthrough vectors cover the corner cases, then random traffic runs.
module tb_bn_pipe_slice;

  localparam int DW = 16;
  localparam int CH = 2;
  localparam int ST = 2;
  localparam int CW = 16;
  localparam int OW = $clog2(ST + 1);
  localparam int BW = CH*DW + 4*DW + 1;

  typedef logic [BW-1:0] beat_t;
  typedef struct { beat_t beat; int acc; } entry_t;
  typedef struct {
    logic [CH*DW-1:0] data;
    logic [DW-1:0]    mean, std, gamma, beta;
    logic             last;
    logic [CH*DW-1:0] exp_data;
    logic [DW-1:0]    exp_beta;
    logic             exp_last;
  } vec_t;

  logic           clk, rst, flush, in_valid, in_ready, in_last;
  logic [CH*DW-1:0] in_data, out_data;
  logic [DW-1:0]  in_mean, in_std, in_gamma, in_beta;
  logic [DW-1:0]  out_mean, out_std, out_gamma, out_beta;
  logic           fifo_empty_in, fifo_full_in, fifo_empty_out, fifo_full_out;
  logic           out_valid, out_ready, out_last;
  logic [OW-1:0]  occupancy;
`ifdef BN_PIPE_STALL_CNT_EN
  logic [CW-1:0]  stall_cnt;
`endif

  bn_pipe_slice #(.DATA_WIDTH(DW), .CHANNELS(CH), .STAGES(ST), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mean(in_mean), .in_std(in_std), .in_gamma(in_gamma), .in_beta(in_beta),
    .in_last(in_last), .fifo_empty_in(fifo_empty_in), .fifo_full_in(fifo_full_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_mean(out_mean), .out_std(out_std), .out_gamma(out_gamma), .out_beta(out_beta),
    .out_last(out_last), .fifo_empty_out(fifo_empty_out), .fifo_full_out(fifo_full_out),
    .occupancy(occupancy)
`ifdef BN_PIPE_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     checks, errors, cyc, n_out, stall_model;
  bit     armed, strict_lat, accepted_now;
  entry_t sb[$];
  bit     sb_e[$], sb_f[$];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic beat_t in_beat();
    return {in_data, in_mean, in_std, in_gamma, in_beta, in_last};
  endfunction

  function automatic beat_t out_beat();
    return {out_data, out_mean, out_std, out_gamma, out_beta, out_last};
  endfunction

  task automatic model_reset();
    sb.delete();
    sb_e.delete();
    sb_f.delete();
    for (int i = 0; i < ST; i++) begin
      sb_e.push_back(1'b1);
      sb_f.push_back(1'b0);
    end
    stall_model = 0;
    armed = 1'b1;
  endtask

  // Runs between edges: compares DUT against the model, then advances the
  // model by what the coming edge will do.
  task automatic check_cycle();
    bit exp_rdy;
    int lat;
    accepted_now = 1'b0;
    if (armed) begin
      exp_rdy = !flush && (sb.size() < ST || out_ready);
      check("occupancy", occupancy, sb.size());
      check("in_ready", in_ready, exp_rdy);
      check("fifo_empty_out", fifo_empty_out, sb_e[0]);
      check("fifo_full_out", fifo_full_out, sb_f[0]);
`ifdef BN_PIPE_STALL_CNT_EN
      check("stall_cnt", stall_cnt, stall_model);
`endif
      if (sb.size() == 0) begin
        check("out_valid_idle", out_valid, 0);
      end else if (out_valid) begin
        check("out_beat", out_beat(), sb[0].beat);
        if (out_ready) begin
          lat = cyc - sb[0].acc;
          if (strict_lat) check("latency", lat, ST);
          else            check("latency_min", lat >= ST, 1);
          void'(sb.pop_front());
          n_out++;
        end
      end
      if (!rst) begin
        if (flush) stall_model = 0;
        else if (out_valid && !out_ready && stall_model < (1 << CW) - 1) stall_model++;
        if (flush) sb.delete();
        else if (in_valid && exp_rdy) begin
          sb.push_back('{beat: in_beat(), acc: cyc});
          accepted_now = 1'b1;
        end
        void'(sb_e.pop_front());
        void'(sb_f.pop_front());
        sb_e.push_back(fifo_empty_in);
        sb_f.push_back(fifo_full_in);
      end
    end
    if (rst) model_reset();
    cyc++;
  endtask

  task automatic cycle();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [DW-1:0] k, input logic last);
    in_data  = {k, k};
    in_mean  = k + 16'h0100;
    in_std   = k + 16'h0200;
    in_gamma = k + 16'h0300;
    in_beta  = k + 16'h0400;
    in_last  = last;
  endtask

  vec_t vecs[4];
  int   n0, n_acc, t;
  logic [DW-1:0] k_next;

  initial begin
    checks = 0; errors = 0; cyc = 0; n_out = 0; stall_model = 0;
    armed = 1'b0; strict_lat = 1'b0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    fifo_empty_in = 1'b1; fifo_full_in = 1'b0;
    set_beat(16'h0, 1'b0);

    vecs[0] = '{32'h8000_8000, 16'h7FFF, 16'h0001, 16'h8001, 16'hFFFF, 1'b1, 32'h8000_8000, 16'hFFFF, 1'b1};
    vecs[1] = '{32'hFFFF_0000, 16'h8000, 16'hFFFE, 16'h0000, 16'h1234, 1'b0, 32'hFFFF_0000, 16'h1234, 1'b0};
    vecs[2] = '{32'h7FFF_8001, 16'h0F0F, 16'hF0F0, 16'hAAAA, 16'h8000, 1'b1, 32'h7FFF_8001, 16'h8000, 1'b1};
    vecs[3] = '{32'h1234_ABCD, 16'h5555, 16'h0101, 16'hFEDC, 16'h0000, 1'b0, 32'h1234_ABCD, 16'h0000, 1'b0};

    // Reset with arbitrary inputs driven.
    repeat (2) begin
      in_valid = 1'($urandom); flush = 1'($urandom); out_ready = 1'($urandom);
      fifo_empty_in = 1'($urandom); fifo_full_in = 1'($urandom);
      in_data = $urandom; in_beta = 16'($urandom);
      cycle();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    fifo_empty_in = 1'b1; fifo_full_in = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_fifo_empty_out", fifo_empty_out, 1);
    check("rst_fifo_full_out", fifo_full_out, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_out_data", out_data, 0);

    // Streaming 8 beats with out_ready held high: exact latency, in order.
    strict_lat = 1'b1; out_ready = 1'b1; n0 = n_out;
    for (int k = 1; k <= 8; k++) begin
      set_beat(DW'(k), k == 8);
      in_valid = 1'b1;
      cycle();
      check($sformatf("stream_accept_%0d", k), accepted_now, 1);
    end
    in_valid = 1'b0;
    repeat (ST + 2) cycle();
    check("stream_count", n_out - n0, 8);
    strict_lat = 1'b0;

    // Backpressure: out_ready low for 5 cycles with in_valid high.
    out_ready = 1'b0; n_acc = 0; k_next = 16'h0020;
    set_beat(k_next, 1'b0);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      cycle();
      if (accepted_now) begin
        n_acc++;
        k_next++;
        set_beat(k_next, 1'b0);
      end
    end
    check("bp_accepted", n_acc, ST);
    check("bp_in_ready", in_ready, 0);
    check("bp_occupancy", occupancy, ST);
    in_valid = 1'b0; out_ready = 1'b1; n0 = n_out;
    repeat (ST + 2) cycle();
    check("bp_drained", n_out - n0, ST);
    check("bp_empty", occupancy, 0);

    // Sideband: one-cycle full pulse while the data path is stalled.
    out_ready = 1'b0;
    fifo_full_in = 1'b1;
    cycle();
    fifo_full_in = 1'b0;
    for (int k = 1; k <= ST + 2; k++) begin
      check($sformatf("sideband_full_%0d", k), fifo_full_out, k == ST);
      cycle();
    end

    // Flush with a simultaneous input beat while the pipe is full.
    out_ready = 1'b0;
    for (int k = 0; k < 4 && occupancy < ST; k++) begin
      set_beat(DW'(16'h0040 + k), 1'b0);
      in_valid = 1'b1;
      cycle();
    end
    check("flush_pre_occ", occupancy, ST);
    flush = 1'b1; in_valid = 1'b1; set_beat(16'hDEAD, 1'b1);
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", out_valid, 0);
    check("flush_occupancy", occupancy, 0);
    out_ready = 1'b1; n0 = n_out;
    repeat (4) cycle();
    check("flush_no_output", n_out - n0, 0);

    // Table-driven passthrough vectors (sign bits, last marker).
    for (int v = 0; v < 4; v++) begin
      in_data = vecs[v].data; in_mean = vecs[v].mean; in_std = vecs[v].std;
      in_gamma = vecs[v].gamma; in_beta = vecs[v].beta; in_last = vecs[v].last;
      in_valid = 1'b1; out_ready = 1'b1;
      cycle();
      in_valid = 1'b0; in_last = 1'b0;
      t = 0;
      while (!out_valid && t < 10) begin
        cycle();
        t++;
      end
      check($sformatf("vec%0d_seen", v), out_valid, 1);
      check($sformatf("vec%0d_data", v), out_data, vecs[v].exp_data);
      check($sformatf("vec%0d_beta", v), out_beta, vecs[v].exp_beta);
      check($sformatf("vec%0d_last", v), out_last, vecs[v].exp_last);
      cycle();
      check($sformatf("vec%0d_single", v), out_valid, 0);
    end

    // Random traffic against the scoreboard.
    for (int c = 0; c < 1500; c++) begin
      rst           = ($urandom_range(0, 199) == 0);
      flush         = ($urandom_range(0, 29) == 0);
      in_valid      = ($urandom_range(0, 2) != 0);
      out_ready     = ($urandom_range(0, 3) != 0);
      fifo_empty_in = 1'($urandom);
      fifo_full_in  = 1'($urandom);
      in_data = $urandom; in_mean = 16'($urandom); in_std = 16'($urandom);
      in_gamma = 16'($urandom); in_beta = 16'($urandom); in_last = 1'($urandom);
      cycle();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (ST + 3) cycle();
    check("final_drain", occupancy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
